// File: rtl/exe_mc_alu_if.sv
// EX-stage bus between the ID/EX register, the execute unit and the EX/MEM register.
// master drives the instruction, slave (exe_mc_alu) returns the result and stall.
interface exe_mc_alu_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic [3:0]       exe_cmd;
    logic [WIDTH-1:0] val1;
    logic [WIDTH-1:0] val2;
    logic [WIDTH-1:0] result;
    logic             out_valid;
    logic             stall;
    logic             busy;

    modport master (
        output in_valid, exe_cmd, val1, val2,
        input  result, out_valid, stall, busy
    );

    modport slave (
        input  in_valid, exe_cmd, val1, val2,
        output result, out_valid, stall, busy
    );
endinterface

// File: rtl/exe_mc_alu.sv
// MIPS EX-stage ALU: combinational EXE_CMD ops plus iterative MUL and, when
// EXE_DIV_EN is defined, restoring DIVU/REMU behind a stall handshake.
//
// state | meaning
// IDLE  | single-cycle ops pass through; a multi-cycle op is latched here
// RUN   | one multiply/divide iteration per cycle, pipeline stalled
// DONE  | registered result presented for one cycle, then back to IDLE
module exe_mc_alu #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input logic         clk,
    input logic         rst,
    exe_mc_alu_if.slave alu
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [3:0] CMD_ADD  = 4'b0000;
    localparam logic [3:0] CMD_SUB  = 4'b0010;
    localparam logic [3:0] CMD_AND  = 4'b0100;
    localparam logic [3:0] CMD_OR   = 4'b0101;
    localparam logic [3:0] CMD_NOR  = 4'b0110;
    localparam logic [3:0] CMD_XOR  = 4'b0111;
    localparam logic [3:0] CMD_SLL  = 4'b1000;
    localparam logic [3:0] CMD_SRA  = 4'b1001;
    localparam logic [3:0] CMD_SRL  = 4'b1010;
    localparam logic [3:0] CMD_MUL  = 4'b1011;
    localparam logic [3:0] CMD_DIVU = 4'b1100;
    localparam logic [3:0] CMD_REMU = 4'b1101;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_nxt;
    logic               busy_q;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   opa;
    logic [WIDTH-1:0]   opb;
    logic [WIDTH-1:0]   res_q;

    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   alu_comb;
    logic [WIDTH-1:0]   mul_acc_nxt;
    logic [WIDTH-1:0]   iter_res;
    logic               is_multi;
    logic               accept;
    logic               last_iter;

`ifdef EXE_DIV_EN
    logic [3:0]         cmd_q;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   rem_nxt;
    logic [WIDTH-1:0]   quo_nxt;
    logic               div_op;
`endif

    assign shamt = alu.val2[SHAMT_W-1:0];

    always_comb begin
        alu_comb = '0;
        case (alu.exe_cmd)
            CMD_ADD: alu_comb = alu.val1 + alu.val2;
            CMD_SUB: alu_comb = alu.val1 - alu.val2;
            CMD_AND: alu_comb = alu.val1 & alu.val2;
            CMD_OR:  alu_comb = alu.val1 | alu.val2;
            CMD_NOR: alu_comb = ~(alu.val1 | alu.val2);
            CMD_XOR: alu_comb = alu.val1 ^ alu.val2;
            CMD_SLL: alu_comb = alu.val1 << shamt;
            CMD_SRA: alu_comb = $signed(alu.val1) >>> shamt;
            CMD_SRL: alu_comb = alu.val1 >> shamt;
            default: alu_comb = '0;
        endcase
    end

`ifdef EXE_DIV_EN
    assign is_multi = (alu.exe_cmd == CMD_MUL) || (alu.exe_cmd == CMD_DIVU) ||
                      (alu.exe_cmd == CMD_REMU);
`else
    assign is_multi = (alu.exe_cmd == CMD_MUL);
`endif

    assign accept    = (state == IDLE) && alu.in_valid && !rst && is_multi;
    assign last_iter = (cnt == CNT_W'(1));

    // Multiply: opa is the multiplicand shifting left, opb the multiplier shifting right.
    assign mul_acc_nxt = acc + (opb[0] ? opa : '0);

`ifdef EXE_DIV_EN
    // Divide: acc holds the partial remainder, opa the dividend that fills with quotient
    // bits, opb the divisor. A zero divisor never borrows, which yields all-ones / val1.
    assign div_op    = (cmd_q != CMD_MUL);
    assign div_shift = {acc, opa[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, opb});
    assign rem_nxt   = div_ge ? WIDTH'(div_shift - {1'b0, opb}) : WIDTH'(div_shift);
    assign quo_nxt   = {opa[WIDTH-2:0], div_ge};
    assign iter_res  = div_op ? ((cmd_q == CMD_DIVU) ? quo_nxt : rem_nxt) : mul_acc_nxt;
`else
    assign iter_res  = mul_acc_nxt;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (last_iter) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            opa    <= '0;
            opb    <= '0;
            res_q  <= '0;
`ifdef EXE_DIV_EN
            cmd_q  <= '0;
`endif
        end else begin
            state  <= state_nxt;
            busy_q <= (state_nxt == RUN);
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc <= '0;
                        opa <= alu.val1;
                        opb <= alu.val2;
                        cnt <= CNT_W'(WIDTH);
`ifdef EXE_DIV_EN
                        cmd_q <= alu.exe_cmd;
`endif
                    end
                end
                RUN: begin
                    cnt <= cnt - CNT_W'(1);
`ifdef EXE_DIV_EN
                    if (div_op) begin
                        acc <= rem_nxt;
                        opa <= quo_nxt;
                    end else
`endif
                    begin
                        acc <= mul_acc_nxt;
                        opa <= opa << 1;
                        opb <= opb >> 1;
                    end
                    if (last_iter) res_q <= iter_res;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        alu.result    = '0;
        alu.out_valid = 1'b0;
        alu.stall     = busy_q;
        alu.busy      = busy_q;
        case (state)
            IDLE: begin
                if (alu.in_valid && !rst) begin
                    if (is_multi) begin
                        alu.stall = 1'b1;
                    end else begin
                        alu.result    = alu_comb;
                        alu.out_valid = 1'b1;
                    end
                end
            end
            DONE: begin
                // The instruction on the inputs is the one retiring; do not decode it.
                if (!rst) begin
                    alu.result    = res_q;
                    alu.out_valid = 1'b1;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: doc/exe_mc_alu.md
# exe_mc_alu

Parametrised execute unit for the pipelined MIPS datapath. It keeps the existing 4-bit EXE_CMD ALU encodings as zero-latency combinational operations and adds iterative multiply, unsigned divide and unsigned remainder. The iterative operations run over multiple cycles behind a stall handshake. The unit sits in the EX stage, driven by the ID/EX register, and its result feeds the EX/MEM register.

## Interface
- WIDTH, 32: operand and result width.
- SHAMT_W, $clog2(WIDTH): number of low val2 bits used as the shift amount.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  EX stage holds a valid instruction.
- exe_cmd  in  4  operation code.
- val1  in  WIDTH  first operand.
- val2  in  WIDTH  second operand (register or sign-extended immediate).
- result  out  WIDTH  operation result.
- out_valid  out  1  result is valid this cycle.
- stall  out  1  freeze PC, IF/ID and ID/EX this cycle.
- busy  out  1  an iterative operation is in progress (state RUN).

## Operation
- Single-cycle codes:
  - 0000 ADD, 0010 SUB, 0100 AND, 0101 OR, 0110 NOR, 0111 XOR.
  - 1000 SLL, 1001 SRA (arithmetic, sign-filled), 1010 SRL.
- Shift amount is val2[SHAMT_W-1:0] only; the upper val2 bits are ignored.
- All arithmetic is modulo 2^WIDTH. There is no overflow flag.
- Unlisted codes are single-cycle and give result 0.
- Multi-cycle codes:
  - 1011 MUL: low WIDTH bits of val1*val2; signed and unsigned give identical low bits. Implemented as a shift-add loop, one bit per cycle.
  - 1100 DIVU: unsigned val1/val2, restoring division, one quotient bit per cycle.
  - 1101 REMU: unsigned val1%val2, same divider.
- Divide by zero:
  - DIVU gives all ones.
  - REMU gives val1.
  - Both still take the full iteration count.
- FSM states:
  - IDLE:
    - With in_valid and a single-cycle code: result is combinational from the inputs, out_valid=1, stall=0, state stays IDLE.
    - With in_valid and a multi-cycle code: stall=1 combinationally, out_valid=0. At the clock edge, operands and command are latched, iteration counter is set to WIDTH, state goes to RUN.
    - With in_valid=0: result=0, out_valid=0.
  - RUN:
    - One iteration per cycle; counter decrements.
    - stall=1, busy=1, out_valid=0, result=0.
    - Inputs are ignored; the pipeline holds them stable.
    - At the edge where the counter reaches 0, the final value is written to the result register and state goes to DONE.
  - DONE:
    - result = result register, out_valid=1, stall=0, busy=0.
    - in_valid is ignored: the presented instruction is the one retiring.
    - Next state is IDLE unconditionally.
- A new instruction can only be accepted in IDLE. Consecutive multi-cycle operations are therefore separated by the DONE cycle.

## Timing
- Single-cycle ops: 0-cycle latency, purely combinational from val1, val2 and exe_cmd.
- Multi-cycle ops:
  - Accept cycle A is in IDLE.
  - stall is high in cycle A and in the following WIDTH RUN cycles, i.e. WIDTH+1 cycles in total.
  - out_valid goes high in cycle A+WIDTH+1, lasting one cycle.
- busy is registered; it is high exactly during the RUN cycles.
- stall combines busy with the IDLE accept-decode term.
- Reset values: state IDLE, result register 0, counter 0, busy 0. With in_valid=0, result=0, out_valid=0 and stall=0.
- rst has priority over everything:
  - Reset during RUN or DONE aborts the operation; no out_valid is produced.
  - State is IDLE on the next cycle.
  - in_valid is ignored while rst=1.

## Configuration
- EXE_DIV_EN defined: the divider datapath is built; 1100 and 1101 behave as described above.
- EXE_DIV_EN undefined: no divider logic is built. 1100 and 1101 are treated as unlisted single-cycle codes (result 0, no stall). MUL is unaffected.

## Test plan
- ADD/SUB/SRA, WIDTH=32:
  - ADD val1=1546, val2=-1546 -> result 0, out_valid=1, stall=0 in the same cycle.
  - SRA 0xFFFFF9F6 by 2 -> 0xFFFFFE7D.
  - SLL 1 by val2=0x00000024 -> 0x00000010 (only the low 5 bits are used).
- MUL 3 * 0xFFFFFFFB:
  - stall high for 33 cycles.
  - out_valid pulse on the 34th cycle with result 0xFFFFFFF1.
  - busy high for 32 cycles.
- DIVU/REMU, EXE_DIV_EN defined:
  - 100/7 -> 14.
  - 100%7 -> 2.
  - 5/0 -> 0xFFFFFFFF.
  - 5%0 -> 5.
  - Each takes 33 stall cycles.
- Back-to-back: MUL 6*7 held until DONE, then ADD 1+2 presented.
  - DONE cycle gives 42 with the held MUL still on the inputs and not re-accepted.
  - Next cycle gives 3, combinationally.
- Reset mid-operation: rst asserted in RUN cycle 10 of a MUL.
  - Next cycle: busy=0, stall=0, out_valid=0.
  - No out_valid appears later.
  - A subsequent ADD 2+2 gives 4.
- Without EXE_DIV_EN: DIVU 100/7 -> result 0, out_valid=1, stall=0 in the same cycle.
